rtc_hms: RTL and testbench
==========================

RTC_HMS -- requirements
Module: rtc_hms

Interface
REQ-001 Parameter HOURS, default 24, meaning hour-field modulus; legal values 12 or 24; hour range 00..HOURS-1.
REQ-002 clk  input  1  system clock (40 kHz), all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_in  input  1  1 Hz square wave from the clock divider; each rising edge = one second.
REQ-005 set_en  input  1  level; high requests SET mode (counting paused, manual adjust).
REQ-006 sel  input  2  field select in SET: 00 seconds, 01 minutes, 10 hours, 11 none.
REQ-007 inc  input  1  push-button level; each rising edge increments the selected field in SET.
REQ-008 sec  output  8  seconds, packed BCD {tens[7:4], units[3:0]}, 00..59.
REQ-009 min  output  8  minutes, packed BCD, 00..59.
REQ-010 hour  output  8  hours, packed BCD, 00..HOURS-1.
REQ-011 sec_pulse  output  1  one-cycle strobe on each tick-driven second advance.
REQ-012 day_wrap  output  1  one-cycle strobe when tick advance rolls HOURS-1:59:59 to 00:00:00.

Function
REQ-013 tick_in and inc SHALL each pass through a 3-register chain (s1,s2,s3); edge = s2 & ~s3.
REQ-014 Latency: tick_in first sampled high at edge N -> counters and sec_pulse SHALL change at edge N+2.
REQ-015 inc edge latency SHALL match REQ-014 (field changes at edge N+2).
REQ-016 FSM states RUN and SET; RUN->SET on the edge where set_en=1 is sampled; SET->RUN on the edge where set_en=0 is sampled.
REQ-017 Tick/inc edges SHALL be acted on according to the state register value in that cycle, not set_en.
REQ-018 RUN, tick edge: seconds +1; 59->00 carries to minutes; minutes 59->00 carries to hours; hours HOURS-1->00.
REQ-019 All digit arithmetic SHALL be BCD: units 9->0 with tens +1; no digit SHALL ever hold A-F.
REQ-020 sec_pulse SHALL be 1 for exactly one cycle per RUN tick edge, else 0.
REQ-021 day_wrap SHALL be 1 in the same cycle as sec_pulse only for the HOURS-1:59:59 -> 00:00:00 advance.
REQ-022 RUN: inc edges SHALL be ignored and discarded.
REQ-023 SET: tick edges SHALL be ignored, not queued; sec_pulse and day_wrap stay 0.
REQ-024 SET, inc edge: selected field +1, wrapping within its own range (59->00, HOURS-1->00) with no carry into other fields.
REQ-025 SET with sel=11: inc edges SHALL change nothing.
REQ-026 Time values SHALL be preserved across RUN<->SET transitions; exiting SET resumes counting from the set value.
REQ-027 Holding inc high SHALL produce exactly one increment per rising edge, none while held.

Reset
REQ-028 rst_n low SHALL immediately set sec=min=hour=8'h00, sec_pulse=0, day_wrap=0, state=RUN.
REQ-029 All synchronizer registers SHALL reset to 1, so no edge is detected at release regardless of tick_in/inc level.
REQ-030 Reset asserted mid-SET or mid-advance SHALL abort the operation with no partial update after release.
REQ-031 First advance after release SHALL require a low-then-high transition on tick_in.

Verification
REQ-032 Reset, 5 tick_in rising edges in RUN -> sec=8'h05, five sec_pulse strobes, each exactly one cycle, 2 edges after sampled rise.
REQ-033 Preload via SET to 23:59:58, RUN, 2 ticks -> 23:59:59 then 00:00:00; day_wrap=1 only with the second sec_pulse.
REQ-034 HOURS=12, preload 11:59:59, 1 tick -> 00:00:00 with day_wrap=1; sec 09->10 shows 8'h10 not 8'h0A.
REQ-035 SET, sel=01, 61 inc edges from min=00 -> min=8'h01, hour/sec unchanged; ticks applied during SET produce no change or pulses.
REQ-036 tick_in held high through rst_n release -> no advance; next low-high edge -> sec=8'h01.
REQ-037 rst_n pulsed low during SET with inc edge in flight -> all outputs 00, state RUN, no increment after release.

Source files
------------

// File: rtl/rtc_hms.sv
// rtl/rtc_hms.sv - BCD hours/minutes/seconds real-time clock with manual set mode
module rtc_hms #(
    parameter int HOURS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       set_en,
    input  logic [1:0] sel,
    input  logic       inc,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       sec_pulse,
    output logic       day_wrap
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    // Highest legal hour value in packed BCD.
    localparam logic [7:0] HOUR_MAX = (HOURS == 12) ? 8'h11 : 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;

    state_t     state;
    logic [2:0] tick_sync;   // [0]=s1, [1]=s2, [2]=s3
    logic [2:0] inc_sync;
    logic       tick_edge;
    logic       inc_edge;

    // Advance a packed BCD value by one, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Synchronize tick_in and inc; reset to ones so a high level at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync <= 3'b111;
            inc_sync  <= 3'b111;
        end else begin
            tick_sync <= {tick_sync[1:0], tick_in};
            inc_sync  <= {inc_sync[1:0], inc};
        end
    end

    assign tick_edge = tick_sync[1] & ~tick_sync[2];
    assign inc_edge  = inc_sync[1] & ~inc_sync[2];

    // Mode FSM and time counters; edges are acted on by the current state, not set_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            sec       <= 8'h00;
            min       <= 8'h00;
            hour      <= 8'h00;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            state     <= set_en ? SET : RUN;
            case (state)
                RUN: begin
                    if (tick_edge) begin
                        sec_pulse <= 1'b1;
                        sec       <= bcd_inc(sec, MS_MAX);
                        if (sec == MS_MAX) begin
                            min <= bcd_inc(min, MS_MAX);
                            if (min == MS_MAX) begin
                                hour <= bcd_inc(hour, HOUR_MAX);
                                if (hour == HOUR_MAX) begin
                                    day_wrap <= 1'b1;
                                end
                            end
                        end
                    end
                end
                SET: begin
                    if (inc_edge) begin
                        case (sel)
                            2'b00:   sec  <= bcd_inc(sec, MS_MAX);
                            2'b01:   min  <= bcd_inc(min, MS_MAX);
                            2'b10:   hour <= bcd_inc(hour, HOUR_MAX);
                            default: ;
                        endcase
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_hms.sv
// tb/tb_rtc_hms.sv - directed self-checking bench for rtc_hms (24h and 12h instances)
`timescale 1ns/1ps
module tb_rtc_hms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       set_en;
    logic [1:0] sel;
    logic       inc;
    logic [7:0] sec, min, hour;
    logic       sec_pulse, day_wrap;
    logic [7:0] sec12, min12, hour12;
    logic       sec_pulse12, day_wrap12;

    int tests_run = 0;
    int fails     = 0;

    int n_pulse, n_wrap, n_wrap12, first_cyc;

    always #5 clk = ~clk;

    rtc_hms #(.HOURS(24)) u24 (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_en(set_en), .sel(sel), .inc(inc),
        .sec(sec), .min(min), .hour(hour), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
    );

    rtc_hms #(.HOURS(12)) u12 (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_en(set_en), .sel(sel), .inc(inc),
        .sec(sec12), .min(min12), .hour(hour12), .sec_pulse(sec_pulse12), .day_wrap(day_wrap12)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick_in high/low period, recording strobe activity of both instances.
    task automatic do_tick();
        n_pulse   = 0;
        n_wrap    = 0;
        n_wrap12  = 0;
        first_cyc = 0;
        tick_in   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) tick_in = 1'b0;
            cyc(1);
            if (sec_pulse) begin
                n_pulse++;
                if (first_cyc == 0) first_cyc = i;
            end
            if (day_wrap)   n_wrap++;
            if (day_wrap12) n_wrap12++;
        end
    endtask

    task automatic do_inc();
        inc = 1'b1;
        cyc(3);
        inc = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tick_in = 1'b0;
        set_en  = 1'b0;
        inc     = 1'b0;
        sel     = 2'b00;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({hour, min, sec, sec_pulse, day_wrap} !== 26'h0) begin
            fails++;
            $display("FAIL reset_state: got %h:%h:%h p=%b w=%b, want 00:00:00 p=0 w=0",
                     hour, min, sec, sec_pulse, day_wrap);
        end
    endtask

    task automatic test_ticks();
        for (int k = 0; k < 5; k++) begin
            do_tick();
            tests_run++;
            if (n_pulse !== 1 || first_cyc !== 3) begin
                fails++;
                $display("FAIL tick_pulse%0d: got %0d pulses first at %0d, want 1 at 3", k, n_pulse, first_cyc);
            end
        end
        tests_run++;
        if (sec !== 8'h05) begin
            fails++;
            $display("FAIL five_ticks: sec=%h want 05", sec);
        end
        repeat (5) do_tick();
        tests_run++;
        if (sec !== 8'h10 || sec12 !== 8'h10) begin
            fails++;
            $display("FAIL bcd_carry: sec=%h sec12=%h want 10", sec, sec12);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        set_en = 1'b1;
        cyc(2);
        sel = 2'b10;
        repeat (23) do_inc();
        sel = 2'b01;
        repeat (59) do_inc();
        sel = 2'b00;
        repeat (58) do_inc();
        set_en = 1'b0;
        cyc(2);
        tests_run++;
        if ({hour, min, sec} !== 24'h235958 || {hour12, min12, sec12} !== 24'h115958) begin
            fails++;
            $display("FAIL preload: got %h:%h:%h / %h:%h:%h want 23:59:58 / 11:59:58",
                     hour, min, sec, hour12, min12, sec12);
        end
        do_tick();
        tests_run++;
        if ({hour, min, sec} !== 24'h235959 || n_wrap !== 0 || n_wrap12 !== 0 || n_pulse !== 1) begin
            fails++;
            $display("FAIL tick_to_235959: got %h:%h:%h wrap=%0d/%0d pulses=%0d want 23:59:59 0/0 1",
                     hour, min, sec, n_wrap, n_wrap12, n_pulse);
        end
        do_tick();
        tests_run++;
        if ({hour, min, sec} !== 24'h000000 || n_wrap !== 1 || n_pulse !== 1) begin
            fails++;
            $display("FAIL day_wrap24: got %h:%h:%h wrap=%0d pulses=%0d want 00:00:00 1 1",
                     hour, min, sec, n_wrap, n_pulse);
        end
        tests_run++;
        if ({hour12, min12, sec12} !== 24'h000000 || n_wrap12 !== 1) begin
            fails++;
            $display("FAIL day_wrap12: got %h:%h:%h wrap=%0d want 00:00:00 1",
                     hour12, min12, sec12, n_wrap12);
        end
    endtask

    task automatic test_set_min();
        do_reset();
        set_en = 1'b1;
        cyc(2);
        sel = 2'b01;
        repeat (61) do_inc();
        tests_run++;
        if ({hour, min, sec} !== 24'h000100) begin
            fails++;
            $display("FAIL set_min_wrap: got %h:%h:%h want 00:01:00", hour, min, sec);
        end
        do_tick();
        tests_run++;
        if (n_pulse !== 0 || n_wrap !== 0 || {hour, min, sec} !== 24'h000100) begin
            fails++;
            $display("FAIL tick_in_set: pulses=%0d time=%h:%h:%h want 0 00:01:00", n_pulse, hour, min, sec);
        end
        sel = 2'b11;
        do_inc();
        tests_run++;
        if ({hour, min, sec} !== 24'h000100) begin
            fails++;
            $display("FAIL sel_none: got %h:%h:%h want 00:01:00", hour, min, sec);
        end
        sel = 2'b00;
        inc = 1'b1;
        cyc(10);
        inc = 1'b0;
        cyc(3);
        tests_run++;
        if (sec !== 8'h01) begin
            fails++;
            $display("FAIL inc_hold: sec=%h want 01", sec);
        end
        set_en = 1'b0;
        cyc(2);
        do_tick();
        tests_run++;
        if ({hour, min, sec} !== 24'h000102 || n_pulse !== 1) begin
            fails++;
            $display("FAIL resume: got %h:%h:%h pulses=%0d want 00:01:02 1", hour, min, sec, n_pulse);
        end
    endtask

    task automatic test_run_inc_ignored();
        sel = 2'b00;
        do_inc();
        tests_run++;
        if ({hour, min, sec} !== 24'h000102) begin
            fails++;
            $display("FAIL run_inc: got %h:%h:%h want 00:01:02", hour, min, sec);
        end
    endtask

    task automatic test_tick_held_reset();
        rst_n   = 1'b0;
        tick_in = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        tests_run++;
        if (sec !== 8'h00) begin
            fails++;
            $display("FAIL tick_held_release: sec=%h want 00", sec);
        end
        tick_in = 1'b0;
        cyc(3);
        do_tick();
        tests_run++;
        if (sec !== 8'h01 || n_pulse !== 1) begin
            fails++;
            $display("FAIL first_tick_after_reset: sec=%h pulses=%0d want 01 1", sec, n_pulse);
        end
    endtask

    task automatic test_reset_mid_set();
        do_reset();
        set_en = 1'b1;
        cyc(2);
        sel = 2'b00;
        do_inc();
        inc = 1'b1;
        cyc(1);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({hour, min, sec, sec_pulse, day_wrap} !== 26'h0) begin
            fails++;
            $display("FAIL async_reset: got %h:%h:%h p=%b w=%b want all 0", hour, min, sec, sec_pulse, day_wrap);
        end
        set_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        inc = 1'b0;
        cyc(3);
        tests_run++;
        if (sec !== 8'h00) begin
            fails++;
            $display("FAIL no_inc_after_reset: sec=%h want 00", sec);
        end
        do_tick();
        tests_run++;
        if (sec !== 8'h01 || n_pulse !== 1) begin
            fails++;
            $display("FAIL run_after_reset: sec=%h pulses=%0d want 01 1", sec, n_pulse);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_in = 1'b0;
        set_en  = 1'b0;
        inc     = 1'b0;
        sel     = 2'b00;
        test_reset();
        test_ticks();
        test_rollover();
        test_set_min();
        test_run_inc_ignored();
        test_tick_held_reset();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
